fetch_queue_unit: RTL

- Instruction-fetch stage directly downstream of the 5-bit program counter.
- Each cycle it decides whether the PC advances, holds or is redirected, drives PCWrite/PCNext back into the PC, and issues synchronous reads to instruction memory.
- Returned instructions are buffered with their PC tags in a small queue, which feeds decode through a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_unit_if.sv | 33 +++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_queue_unit.sv | 76 +++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   AW / DW        : PC/address and instruction widths
//   fetch_entry_t  : one queued fetch result {pc tag, instruction}
//   PCW_INC/LOAD   : encodings of the PC write-select driven back to the PC
package fetch_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_entry_t;

  localparam logic PCW_INC  = 1'b0;
  localparam logic PCW_LOAD = 1'b1;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bundle of everything the fetch unit exchanges with its neighbours:
//   PC side     : pc_result (in), pc_write / pc_next (out)
//   IMem side   : imem_addr / imem_rd_en (out), imem_data (in, one cycle after rd_en)
//   Control     : redirect_valid / redirect_pc (in)
//   Decode side : if_valid / if_pc / if_instr (out), if_ready (in)
// master = the fetch unit, slave = its environment.
interface fetch_queue_unit_if;
  import fetch_pkg::*;

  logic [AW-1:0] pc_result;
  logic          pc_write;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [DW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;

  modport master (
    input  pc_result, imem_data, redirect_valid, redirect_pc, if_ready,
    output pc_write, pc_next, imem_addr, imem_rd_en, if_valid, if_pc, if_instr
  );

  modport slave (
    output pc_result, imem_data, redirect_valid, redirect_pc, if_ready,
    input  pc_write, pc_next, imem_addr, imem_rd_en, if_valid, if_pc, if_instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, reset (sync, active-low) ; push/push_data ; pop ; flush (clears like reset)
//   count : occupancy 0..Depth ; head : entry at the read pointer (from storage)
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [CntW-1:0] count,
  output fetch_entry_t    head
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_push = push && (count_q != CntW'(Depth));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: decides each cycle whether the PC increments, holds or is
// redirected, issues synchronous IMem reads, and queues returned instructions with
// their PC tags toward decode.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   fif   : fetch_queue_unit_if.master (PC, IMem, redirect and decode handshake)
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input logic               clk,
  input logic               reset,
  fetch_queue_unit_if.master fif
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [CntW-1:0] count;
  fetch_entry_t    head, push_data;
  logic            in_flight_q;
  logic [AW-1:0]   in_flight_pc_q;
  logic            credit, issue, push, pop, flush;

  // Credit counts the outstanding read but ignores a same-cycle pop on purpose:
  // this keeps the issue decision off the decode ready path.
  assign credit = ({1'b0, count} + {{CntW{1'b0}}, in_flight_q}) < (CntW + 1)'(Depth);
  assign issue  = reset && !fif.redirect_valid && credit;

  // A redirect kills both the returning read and any head decode takes this cycle.
  assign flush = fif.redirect_valid;
  assign push  = in_flight_q && !fif.redirect_valid;
  assign pop   = fif.if_valid && fif.if_ready && !fif.redirect_valid;

  assign push_data.pc    = in_flight_pc_q;
  assign push_data.instr = fif.imem_data;

  fetch_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (!reset || fif.redirect_valid) in_flight_q <= 1'b0;
    else                              in_flight_q <= issue;
    if (issue) in_flight_pc_q <= fif.pc_result;
  end

  // PC control: load 0 in reset, load target on redirect, increment on issue, else hold.
  always_comb begin
    fif.imem_addr  = fif.pc_result;
    fif.imem_rd_en = issue;
    fif.pc_write   = PCW_LOAD;
    fif.pc_next    = fif.pc_result;
    if (!reset) begin
      fif.pc_next = '0;
    end else if (fif.redirect_valid) begin
      fif.pc_next = fif.redirect_pc;
    end else if (issue) begin
      fif.pc_write = PCW_INC;
    end
  end

  assign fif.if_valid = reset && (count != '0);
  assign fif.if_pc    = head.pc;
  assign fif.if_instr = head.instr;

endmodule
